// File: rtl/alu_pkg.sv
// Shared ALU encodings, flag positions, request opcodes and sequencer states.
// Pure declarations; no logic lives here.
package alu_pkg;

  localparam logic [3:0] ALU_HOLD = 4'd0;
  localparam logic [3:0] ALU_CMP  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd6;
  localparam logic [3:0] ALU_ADC  = 4'd7;
  localparam logic [3:0] ALU_SUB  = 4'd8;
  localparam logic [3:0] ALU_SBB  = 4'd9;
  localparam logic [3:0] ALU_AND  = 4'd11;
  localparam logic [3:0] ALU_OR   = 4'd12;
  localparam logic [3:0] ALU_XOR  = 4'd13;
  localparam logic [3:0] ALU_CLRF = 4'd15;

  localparam int FLAG_Z = 7;
  localparam int FLAG_S = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_V = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5
  } req_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2,
    ST_CLR  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_mp_op_decode.sv
// Maps a request opcode and word position to the ALU mode; flags opcodes 6-7 as illegal.
// Purely combinational.
module alu_mp_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  input  logic       first_word,
  output logic [3:0] mode,
  output logic       illegal
);

  always_comb begin
    mode    = ALU_HOLD;
    illegal = 1'b0;
    case (op)
      OP_ADD:         mode = first_word ? ALU_ADD : ALU_ADC;
      OP_SUB, OP_CMP: mode = first_word ? ALU_SUB : ALU_SBB;
      OP_AND:         mode = ALU_AND;
      OP_OR:          mode = ALU_OR;
      OP_XOR:         mode = ALU_XOR;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_mp_sequencer.sv
// Multi-precision sequencer: issues one wide op to the 8-bit ALU a word per cycle, LSW first.
// ALU_MP_SEQ_CLEAR_FLAGS_EN adds a one-cycle CLR state (alu_mode=15) before word 0.
module alu_mp_sequencer
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [2:0]                     req_op,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] req_a,
  input  logic [NUM_WORDS*WORD_SIZE-1:0] req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [NUM_WORDS*WORD_SIZE-1:0] rsp_result,
  output logic [3:0]                     rsp_flags,
  output logic                           rsp_err,
  output logic [WORD_SIZE-1:0]           alu_a,
  output logic [WORD_SIZE-1:0]           alu_b,
  output logic [3:0]                     alu_mode,
  input  logic [WORD_SIZE-1:0]           alu_c,
  input  logic [7:0]                     alu_flags
);

  localparam int WIDE = NUM_WORDS * WORD_SIZE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [WIDE-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic            c_q, c_d, v_q, v_d, err_q, err_d;

  logic       in_exec, in_resp, accept, logical_op;
  logic [2:0] dec_op;
  logic [3:0] dec_mode;
  logic       dec_illegal;
  logic       unused_alu_flags;

  assign unused_alu_flags = ^{alu_flags[FLAG_Z], alu_flags[FLAG_S], alu_flags[3:0]};

  // In IDLE the decoder screens the incoming opcode; otherwise it drives the latched one.
  assign dec_op = (state_q == ST_IDLE) ? req_op : op_q;

  alu_mp_op_decode u_decode (
    .op         (dec_op),
    .first_word (idx_q == '0),
    .mode       (dec_mode),
    .illegal    (dec_illegal)
  );

  assign in_exec    = (state_q == ST_EXEC);
  assign in_resp    = (state_q == ST_RESP);
  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign logical_op = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_XOR);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    c_d     = c_q;
    v_d     = v_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          res_d = '0;
          idx_d = '0;
          c_d   = 1'b0;
          v_d   = 1'b0;
          err_d = dec_illegal;
`ifdef ALU_MP_SEQ_CLEAR_FLAGS_EN
          state_d = dec_illegal ? ST_RESP : ST_CLR;
`else
          state_d = dec_illegal ? ST_RESP : ST_EXEC;
`endif
        end
      end
`ifdef ALU_MP_SEQ_CLEAR_FLAGS_EN
      ST_CLR: state_d = ST_EXEC;
`endif
      ST_EXEC: begin
        res_d[int'(idx_q)*WORD_SIZE +: WORD_SIZE] = alu_c;
        c_d = alu_flags[FLAG_C];
        v_d = alu_flags[FLAG_V];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  assign alu_a = in_exec ? a_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] : '0;
  assign alu_b = in_exec ? b_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] : '0;

  always_comb begin
    alu_mode = ALU_HOLD;
    if (in_exec) alu_mode = dec_mode;
`ifdef ALU_MP_SEQ_CLEAR_FLAGS_EN
    if (state_q == ST_CLR) alu_mode = ALU_CLRF;
`endif
  end

  // res_q holds the A-B difference for CMP, so Z/S come from it while A is returned.
  assign rsp_valid  = in_resp;
  assign rsp_err    = in_resp && err_q;
  assign rsp_result = !in_resp ? '0 : (op_q == OP_CMP) ? a_q : res_q;

  always_comb begin
    rsp_flags = 4'b0000;
    if (in_resp) begin
      if (err_q) rsp_flags = 4'b1000;
      else       rsp_flags = {(res_q == '0), res_q[WIDE-1],
                              c_q && !logical_op, v_q && !logical_op};
    end
  end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Bench for alu_mp_sequencer (2 x 8-bit words) with a behavioural 8-bit ALU alongside.
// Directed table, random ops against a wide-arithmetic model, backpressure and mid-op reset.
module tb_alu_mp_sequencer;

  localparam int W  = 8;
  localparam int NW = 2;
  localparam int WD = W * NW;
`ifdef ALU_MP_SEQ_CLEAR_FLAGS_EN
  localparam int CLR_EXTRA = 1;
`else
  localparam int CLR_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [WD-1:0] req_a = '0, req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [WD-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic          rsp_err;
  logic [W-1:0]  alu_a, alu_b, alu_c;
  logic [3:0]    alu_mode;
  logic [7:0]    alu_flags;

  always #5 clk = ~clk;

  alu_mp_sequencer #(.WORD_SIZE(W), .NUM_WORDS(NW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
    .alu_c(alu_c), .alu_flags(alu_flags)
  );

  // Behavioural ALU with a stored carry/borrow for the chaining modes.
  logic       cf_q;
  logic [8:0] t9;
  always_comb begin
    alu_c     = '0;
    alu_flags = '0;
    t9        = '0;
    case (alu_mode)
      4'd6, 4'd7: begin
        t9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, (alu_mode == 4'd7) && cf_q};
        alu_c = t9[7:0];
        alu_flags[5] = t9[8];
        alu_flags[4] = (alu_a[7] == alu_b[7]) && (t9[7] != alu_a[7]);
      end
      4'd8, 4'd9: begin
        t9 = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, (alu_mode == 4'd9) && cf_q};
        alu_c = t9[7:0];
        alu_flags[5] = t9[8];
        alu_flags[4] = (alu_a[7] != alu_b[7]) && (t9[7] != alu_a[7]);
      end
      4'd11: alu_c = alu_a & alu_b;
      4'd12: alu_c = alu_a | alu_b;
      4'd13: alu_c = alu_a ^ alu_b;
      default: alu_c = '0;
    endcase
    alu_flags[7] = (alu_c == '0);
    alu_flags[6] = alu_c[7];
  end

  always @(posedge clk) begin
    if (alu_mode inside {4'd6, 4'd7, 4'd8, 4'd9}) cf_q <= alu_flags[5];
    else if (alu_mode == 4'd15) cf_q <= 1'b0;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h expected %h", name, what, act, exp);
    end
  endtask

  // Reference: whole-operand arithmetic, no word splitting.
  function automatic void ref_op(input logic [2:0] op, input logic [WD-1:0] a, input logic [WD-1:0] b,
                                 output logic [WD-1:0] r, output logic [3:0] f, output logic e);
    logic [WD:0]   t;
    logic [WD-1:0] val;
    logic          c, v;
    e = 1'b0; c = 1'b0; v = 1'b0; t = '0; val = '0;
    case (op)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b}; val = t[WD-1:0]; c = t[WD];
        v = (a[WD-1] == b[WD-1]) && (val[WD-1] != a[WD-1]);
      end
      3'd1, 3'd2: begin
        t = {1'b0, a} - {1'b0, b}; val = t[WD-1:0]; c = t[WD];
        v = (a[WD-1] != b[WD-1]) && (val[WD-1] != a[WD-1]);
      end
      3'd3: val = a & b;
      3'd4: val = a | b;
      3'd5: val = a ^ b;
      default: e = 1'b1;
    endcase
    r = (op == 3'd2) ? a : val;
    f = e ? 4'b1000 : {(val == '0), val[WD-1], c, v};
  endfunction

  function automatic logic [3:0] exp_mode(input logic [2:0] op, input int i);
    case (op)
      3'd0:       return (i == 0) ? 4'd6 : 4'd7;
      3'd1, 3'd2: return (i == 0) ? 4'd8 : 4'd9;
      3'd3:       return 4'd11;
      3'd4:       return 4'd12;
      default:    return 4'd13;
    endcase
  endfunction

  logic [WD-1:0] got_res;
  logic [3:0]    got_flags, got_mode_resp;
  logic          got_err, timed_out;
  int            got_edges;
  logic [3:0]    mode_q[$];

  task automatic run_op(input logic [2:0] op, input logic [WD-1:0] a, input logic [WD-1:0] b, input logic hold_rdy);
    int guard;
    mode_q.delete();
    timed_out = 1'b0;
    rsp_ready = hold_rdy;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!req_ready) timed_out = 1'b1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
    got_edges = 0;
    while (!timed_out) begin
      @(negedge clk);
      if (rsp_valid) break;
      mode_q.push_back(alu_mode);
      @(posedge clk);
      got_edges++;
      if (got_edges > 40) timed_out = 1'b1;
    end
    got_res = rsp_result; got_flags = rsp_flags; got_err = rsp_err; got_mode_resp = alu_mode;
    if (!timed_out) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
    rsp_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [WD-1:0] a, input logic [WD-1:0] b,
                          input logic [WD-1:0] er, input logic [3:0] ef, input logic ee, input logic hold_rdy);
    logic [3:0] exp_m[$];
    run_op(op, a, b, hold_rdy);
    check(name, "timeout", timed_out, 1'b0);
    check(name, "result", got_res, er);
    check(name, "flags", got_flags, ef);
    check(name, "err", got_err, ee);
    check(name, "latency", got_edges, ee ? 0 : NW + CLR_EXTRA);
    check(name, "mode_in_resp", got_mode_resp, 4'd0);
    if (!ee) begin
      if (CLR_EXTRA != 0) exp_m.push_back(4'd15);
      for (int i = 0; i < NW; i++) exp_m.push_back(exp_mode(op, i));
    end
    check(name, "mode_count", mode_q.size(), exp_m.size());
    for (int i = 0; i < exp_m.size() && i < mode_q.size(); i++) check(name, "mode", mode_q[i], exp_m[i]);
  endtask

  typedef struct {
    logic [2:0]    op;
    logic [WD-1:0] a, b, res;
    logic [3:0]    fl;
    logic          err;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [WD-1:0] r, ra, rb;
    logic [3:0]    f;
    logic          e;
    logic [2:0]    rop;
    int            guard;

    vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 1'b0};
    vecs[1]  = '{3'd1, 16'h0100, 16'h0001, 16'h00FF, 4'b0000, 1'b0};
    vecs[2]  = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 4'b1000, 1'b0};
    vecs[3]  = '{3'd2, 16'h0005, 16'h0005, 16'h0005, 4'b1000, 1'b0};
    vecs[4]  = '{3'd3, 16'hF0F0, 16'h0F0F, 16'h0000, 4'b1000, 1'b0};
    vecs[5]  = '{3'd6, 16'h1234, 16'h5678, 16'h0000, 4'b1000, 1'b1};
    vecs[6]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0};
    vecs[7]  = '{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1'b0};
    vecs[8]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0};
    vecs[9]  = '{3'd4, 16'h1200, 16'h0034, 16'h1234, 4'b0000, 1'b0};
    vecs[10] = '{3'd5, 16'hFFFF, 16'h00FF, 16'hFF00, 4'b0100, 1'b0};
    vecs[11] = '{3'd7, 16'hAAAA, 16'h5555, 16'h0000, 4'b1000, 1'b1};

    // Reset state
    #12;
    check("reset", "req_ready", req_ready, 1'b0);
    check("reset", "rsp_valid", rsp_valid, 1'b0);
    check("reset", "rsp_result", rsp_result, 16'h0);
    check("reset", "rsp_flags", rsp_flags, 4'h0);
    check("reset", "rsp_err", rsp_err, 1'b0);
    check("reset", "alu_mode", alu_mode, 4'd0);
    check("reset", "alu_ab", {alu_a, alu_b}, 16'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("post_reset", "req_ready", req_ready, 1'b1);

    for (int i = 0; i < 12; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].res, vecs[i].fl, vecs[i].err, 1'b0);

    // Random ops against the wide model; some with rsp_ready held high throughout.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = WD'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : WD'($urandom);
      ref_op(rop, ra, rb, r, f, e);
      check_op($sformatf("rand%0d", i), rop, ra, rb, r, f, e, 1'($urandom_range(0, 1)));
    end

    // Backpressure: response held for 5 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h1234; req_b = 16'h1111;
    @(posedge clk); #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    check("bp", "valid_seen", rsp_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp", "hold_valid", rsp_valid, 1'b1);
      check("bp", "hold_result", rsp_result, 16'h2345);
      check("bp", "hold_flags", rsp_flags, 4'b0000);
      check("bp", "hold_req_ready", req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("bp", "rsp_valid_after", rsp_valid, 1'b0);
    check("bp", "req_ready_after", req_ready, 1'b1);
    check_op("bp_next", 3'd1, 16'h0005, 16'h0003, 16'h0002, 4'b0000, 1'b0, 1'b0);

    // Reset asserted during EXEC word 1.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h00FF; req_b = 16'h0001;
    @(posedge clk); #1 req_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (alu_mode != 4'd7 && guard < 10) begin @(negedge clk); guard++; end
    check("mid_rst", "reached_word1", alu_mode, 4'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst", "rsp_valid", rsp_valid, 1'b0);
    check("mid_rst", "alu_mode", alu_mode, 4'd0);
    check("mid_rst", "alu_a", alu_a, 8'h00);
    check("mid_rst", "req_ready", req_ready, 1'b0);
    @(negedge clk); rst = 1'b0;
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) e = 1'b1;
    end
    check("mid_rst", "no_response", e, 1'b0);
    check("mid_rst", "req_ready_idle", req_ready, 1'b1);
    check_op("after_rst", 3'd0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mp_sequencer.md
Name: alu_mp_sequencer

Overview:
- Multi-precision sequencer in front of the shared 8-bit combinational ALU.
- Accepts one wide operation (NUM_WORDS words) over a valid/ready handshake and issues it to the ALU one word per cycle, least-significant word first.
- For ADD/SUB, word 0 uses the plain mode and later words use the carry-chaining mode.
- Collects per-word results into a wide result and returns whole-operand flags over a second valid/ready handshake.

Parameters:
- WORD_SIZE, 8, ALU datapath width in bits.
- NUM_WORDS, 4, words per operand (>=2).
- IDX_W, $clog2(NUM_WORDS), word-index counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR; 6-7 illegal.
- req_a  in  NUM_WORDS*WORD_SIZE  operand A.
- req_b  in  NUM_WORDS*WORD_SIZE  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  NUM_WORDS*WORD_SIZE  wide result.
- rsp_flags  out  4  {Z,S,C,V}.
- rsp_err  out  1  illegal opcode.
- alu_a  out  WORD_SIZE  ALU input A.
- alu_b  out  WORD_SIZE  ALU input B.
- alu_mode  out  4  ALU mode select.
- alu_c  in  WORD_SIZE  ALU result.
- alu_flags  in  8  ALU flags: [7]Z, [6]S, [5]C, [4]V.

Behaviour:
- Reset values:
  - State is IDLE.
  - req_ready=0 during reset, then 1 in IDLE.
  - rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_mode=0 (hold); index counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch op, A and B; clear the result register and index.
  - Illegal op: go to RESP with rsp_err=1, result 0, flags 4'b1000.
  - Legal op: go to EXEC.
- EXEC, index i:
  - Drive alu_a/alu_b with word i of the latched operands.
  - alu_mode per op:
    - ADD: 6 (i=0), 7 (i>0).
    - SUB and CMP: 8 (i=0), 9 (i>0).
    - AND 11, OR 12, XOR 13.
  - At the clock edge, capture alu_c into result word i and alu_flags[5:4] into C/V holding registers. Every word overwrites C/V, so the final word's values win.
  - Increment i. After word NUM_WORDS-1, go to RESP.
- Latency: request accepted at edge T; EXEC occupies cycles T+1..T+NUM_WORDS; rsp_valid=1 from cycle T+NUM_WORDS+1.
- RESP:
  - rsp_valid=1; outputs stay stable until rsp_valid&&rsp_ready, then return to IDLE.
  - req_ready=0 in RESP, so there is no same-cycle accept; the next request is taken in IDLE one cycle later.
  - alu_mode=0 outside EXEC.
- Flags:
  - Z = whole wide difference/result == 0, computed by the sequencer, not the per-word ALU Z.
  - S = MSB of the top word.
  - C, V = values from the last word. Logical ops force C=V=0.
- CMP: sequenced like SUB. rsp_result returns the latched req_a unchanged; flags reflect A-B.
- rsp_ready held high while in IDLE/EXEC has no effect.
- Async rst mid-EXEC or in RESP: immediate return to IDLE; partial result discarded; no response is produced.
- Wrap-around: the index counter never exceeds NUM_WORDS-1; ADD/SUB overflow beyond the top word is reported only via C.

Optional Feature:
- Macro: ALU_MP_SEQ_CLEAR_FLAGS_EN.
- Defined: an extra CLR state is inserted between IDLE and EXEC for legal ops. It drives alu_mode=15 for one cycle to zero the ALU flags before word 0. Latency becomes NUM_WORDS+2 cycles to rsp_valid.
- Undefined: no CLR state; IDLE goes straight to EXEC.

Decomposition:
- Package alu_pkg holds:
  - The 4-bit ALU mode localparams (HOLD=0, CMP=2, ADD=6, ADC=7, SUB=8, SBB=9, AND=11, OR=12, XOR=13, CLRF=15).
  - ALU flag bit indices (Z=7, S=6, C=5, V=4).
  - The req_op enum and the FSM state enum.
- One natural sub-module, alu_mp_op_decode: combinational (op, first_word) -> alu_mode, plus an illegal-op flag.

Test Plan:
- WORD_SIZE=8, NUM_WORDS=2, ADD 0x00FF+0x0001 -> rsp_result 0x0100; modes 6 then 7 observed; Z=0, C=0; rsp_valid at T+3.
- SUB 0x0100-0x0001 -> 0x00FF, modes 8 then 9; SUB 0x1234-0x1234 -> 0x0000 with Z=1.
- CMP 0x0005 vs 0x0005 -> rsp_result 0x0005, Z=1; AND 0xF0F0&0x0F0F -> 0x0000, Z=1, C=0, V=0.
- req_op=6 -> rsp_err=1, result 0, flags 4'b1000, rsp_valid at T+1, alu_mode stays 0.
- Hold rsp_ready=0 for 5 cycles -> rsp outputs stable, req_ready=0; after the handshake a second request is accepted one cycle later.
- Assert rst during EXEC word 1 -> state IDLE, rsp_valid=0 and alu_mode=0 immediately; a new ADD then completes correctly.
